// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
package dmem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam int DMEM_DEPTH_DEFAULT   = 256;
   localparam int DMEM_LATENCY_DEFAULT = 2;

   // The latency counter only has to hold LATENCY-1, and LATENCY is at most 15
   localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The contents are deliberately not reset.
module dmem_array #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 256
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [DATA_WIDTH/8-1:0]    be,
   output logic [DATA_WIDTH-1:0]      rdata
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Byte-masked write, or a read into the output register (which holds its value until the next read)
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be[b]) begin
                  mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store in IDLE and
// pulses a response LATENCY cycles later.
// Optional feature: define DMEM_RESPONDER_ERR_EN to flag misaligned or
// out-of-range addresses (the store is suppressed, the load data is 0, mem_err=1).
//
//   state | meaning
//   IDLE  | ready; a request with mem_read or mem_write is accepted at the next edge
//   WAIT  | latency counter running down; request inputs are ignored
//   RESP  | one-cycle mem_resp_valid pulse with data/err, then back to IDLE
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int DEPTH      = DMEM_DEPTH_DEFAULT,
   parameter int LATENCY    = DMEM_LATENCY_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic [DATA_WIDTH-1:0]    mem_write_data,
   input  logic [DATA_WIDTH/8-1:0]  mem_byte_en,
   input  logic                     mem_read,
   input  logic                     mem_write,
   output logic                     mem_req_ready,
   output logic [DATA_WIDTH-1:0]    mem_read_data,
   output logic                     mem_resp_valid,
   output logic                     mem_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);

   dmem_state_e           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic                  store_q;
   logic                  err_q;
   logic                  accept;
   logic                  addr_err;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign accept   = (state_q == IDLE) && (mem_read || mem_write);
   assign word_idx = mem_addr[IDX_W+2:3];

`ifdef DMEM_RESPONDER_ERR_EN
   assign addr_err = (mem_addr[2:0] != 3'b000) || (|(mem_addr >> (IDX_W + 3)));
`else
   // Without error checking the low and upper address bits simply alias
   logic unused_addr_bits;
   assign addr_err         = 1'b0;
   assign unused_addr_bits = ^{mem_addr[2:0], mem_addr[ADDR_WIDTH-1:IDX_W+3]};
`endif

   // Stores commit at the accept edge; loads capture their word at the same edge
   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .en    (accept && !addr_err),
      .we    (mem_write),
      .addr  (word_idx),
      .wdata (mem_write_data),
      .be    (mem_byte_en),
      .rdata (arr_rdata)
   );

   // State and latency counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == DMEM_CNT_W'(1)) begin
               state_d = RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - DMEM_CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Remember the kind of request and its error status until the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         store_q <= mem_write;
         err_q   <= addr_err;
      end
   end

   assign mem_req_ready  = (state_q == IDLE);
   assign mem_resp_valid = (state_q == RESP);
   assign mem_err        = mem_resp_valid && err_q;
   assign mem_read_data  = (mem_resp_valid && !store_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a default-latency instance driven from a vector table
// plus hand sequences, and a LATENCY=1 instance for the back-to-back case.
module tb_dmem_responder;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
      logic [63:0] exp_data;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [63:0] a0_addr = '0, a0_wdata = '0;
   logic [7:0]  a0_be = '0;
   logic        a0_rd = 1'b0, a0_wr = 1'b0;
   logic        r0_ready, r0_valid, r0_err;
   logic [63:0] r0_rdata;

   logic [63:0] a1_addr = '0, a1_wdata = '0;
   logic [7:0]  a1_be = '0;
   logic        a1_rd = 1'b0, a1_wr = 1'b0;
   logic        r1_ready, r1_valid, r1_err;
   logic [63:0] r1_rdata;

   int   n_vec = 0;
   int   n_mis = 0;
   int   negcnt = 0;
   exp_t q0[$];
   exp_t q1[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_addr       (a0_addr),
      .mem_write_data (a0_wdata),
      .mem_byte_en    (a0_be),
      .mem_read       (a0_rd),
      .mem_write      (a0_wr),
      .mem_req_ready  (r0_ready),
      .mem_read_data  (r0_rdata),
      .mem_resp_valid (r0_valid),
      .mem_err        (r0_err)
   );

   dmem_responder #(.LATENCY(1)) dut1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_addr       (a1_addr),
      .mem_write_data (a1_wdata),
      .mem_byte_en    (a1_be),
      .mem_read       (a1_rd),
      .mem_write      (a1_wr),
      .mem_req_ready  (r1_ready),
      .mem_read_data  (r1_rdata),
      .mem_resp_valid (r1_valid),
      .mem_err        (r1_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_resp(input string name, input exp_t e, input logic [63:0] d,
                           input logic er, input int now);
      chk({name, "_data"}, d, e.data);
      chk({name, "_err"}, {63'b0, er}, {63'b0, e.err});
      chk({name, "_cycle"}, 64'(now), 64'(e.due));
   endtask

   // Response monitor: pops the scoreboard on every valid pulse, checks quiet outputs otherwise
   always @(negedge clk) begin
      exp_t e;
      if (r0_valid) begin
         if (q0.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_resp0: got resp_valid=1 expected 0 (t=%0t)", $time);
         end else begin
            e = q0.pop_front();
            chk_resp("resp0", e, r0_rdata, r0_err, negcnt);
         end
      end else begin
         chk("idle0_data", r0_rdata, 64'h0);
         chk("idle0_err", {63'b0, r0_err}, 64'h0);
      end
      if (r1_valid) begin
         if (q1.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_resp1: got resp_valid=1 expected 0 (t=%0t)", $time);
         end else begin
            e = q1.pop_front();
            chk_resp("resp1", e, r1_rdata, r1_err, negcnt);
         end
      end else begin
         chk("idle1_data", r1_rdata, 64'h0);
         chk("idle1_err", {63'b0, r1_err}, 64'h0);
      end
      negcnt++;
   end

   // One request on instance 0 (LATENCY=2) or 1 (LATENCY=1), then wait for its response
   task automatic issue(input int which, input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] data, input logic [7:0] be,
                        input logic [63:0] exp_d, input logic exp_e);
      exp_t e;
      @(negedge clk);
      if (which == 0) begin
         chk("ready0_before_req", {63'b0, r0_ready}, 64'h1);
         a0_rd = rd; a0_wr = wr; a0_addr = addr; a0_wdata = data; a0_be = be;
      end else begin
         chk("ready1_before_req", {63'b0, r1_ready}, 64'h1);
         a1_rd = rd; a1_wr = wr; a1_addr = addr; a1_wdata = data; a1_be = be;
      end
      @(posedge clk);
      e.data = exp_d;
      e.err  = exp_e;
      e.due  = negcnt + ((which == 0) ? 1 : 0);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
      #1;
      a0_rd = 1'b0; a0_wr = 1'b0;
      a1_rd = 1'b0; a1_wr = 1'b0;
      for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         n_vec++;
         n_mis++;
         $display("FAIL resp_timeout: got no response, expected one within 40 cycles");
         q0.delete();
         q1.delete();
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] addr,
                               input logic [63:0] data, input logic [7:0] be,
                               input logic [63:0] exp_d, input logic exp_e);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.data = data; v.be = be;
      v.exp_data = exp_d; v.exp_err = exp_e;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back(mk(0, 1, 64'h10, 64'h1122334455667788, 8'hFF, 64'h0, 0));
      vecs.push_back(mk(1, 0, 64'h10, 64'h0, 8'h00, 64'h1122334455667788, 0));
      vecs.push_back(mk(0, 1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 0));
      vecs.push_back(mk(1, 0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0));
      vecs.push_back(mk(0, 1, 64'h18, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0));
      vecs.push_back(mk(0, 1, 64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h81, 64'h0, 0));
      vecs.push_back(mk(1, 0, 64'h18, 64'h0, 8'h00, 64'hFF23456789ABCDFF, 0));
      vecs.push_back(mk(1, 0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0));
      vecs.push_back(mk(1, 1, 64'h20, 64'h5555555555555555, 8'hFF, 64'h0, 0));
      vecs.push_back(mk(1, 0, 64'h20, 64'h0, 8'h00, 64'h5555555555555555, 0));
      vecs.push_back(mk(0, 1, 64'h0, 64'h7777777777777777, 8'hFF, 64'h0, 0));
`ifdef DMEM_RESPONDER_ERR_EN
      vecs.push_back(mk(1, 0, 64'h13, 64'h0, 8'h00, 64'h0, 1));
      vecs.push_back(mk(0, 1, 64'h800, 64'h9999999999999999, 8'hFF, 64'h0, 1));
      vecs.push_back(mk(1, 0, 64'h0, 64'h0, 8'h00, 64'h7777777777777777, 0));
`else
      vecs.push_back(mk(1, 0, 64'h13, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0));
      vecs.push_back(mk(0, 1, 64'h800, 64'h9999999999999999, 8'hFF, 64'h0, 0));
      vecs.push_back(mk(1, 0, 64'h0, 64'h0, 8'h00, 64'h9999999999999999, 0));
`endif
      vecs.push_back(mk(1, 0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0));

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready0", {63'b0, r0_ready}, 64'h1);
      chk("rst_valid0", {63'b0, r0_valid}, 64'h0);
      chk("rst_ready1", {63'b0, r1_ready}, 64'h1);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         issue(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
               vecs[i].exp_data, vecs[i].exp_err);

      // Continuous mem_read: accept every third cycle, ready low for two cycles after each accept
      @(negedge clk);
      a0_rd = 1'b1; a0_addr = 64'h18;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         chk("cont_ready_accept", {63'b0, r0_ready}, 64'h1);
         @(posedge clk);
         e.data = 64'hFF23456789ABCDFF; e.err = 1'b0; e.due = negcnt + 1;
         q0.push_back(e);
         @(negedge clk);
         chk("cont_ready_wait", {63'b0, r0_ready}, 64'h0);
         @(negedge clk);
         chk("cont_ready_resp", {63'b0, r0_ready}, 64'h0);
         @(negedge clk);
      end
      a0_rd = 1'b0;
      @(negedge clk);
      chk("cont_drained", 64'(q0.size()), 64'h0);

      // Reset in the cycle after a load accept drops the response
      @(negedge clk);
      a0_rd = 1'b1; a0_addr = 64'h10;
      @(posedge clk);
      #1;
      a0_rd = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", {63'b0, r0_ready}, 64'h1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_ready", {63'b0, r0_ready}, 64'h1);
      issue(0, 1, 0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0);

      // LATENCY=1 instance: read+write is a store, response next cycle, then read back
      issue(1, 1, 1, 64'h40, 64'h0BADF00D12345678, 8'hFF, 64'h0, 0);
      issue(1, 1, 0, 64'h40, 64'h0, 8'h00, 64'h0BADF00D12345678, 0);
      issue(1, 0, 1, 64'h40, 64'hFFFFFFFFFFFFFFFF, 8'h30, 64'h0, 0);
      issue(1, 1, 0, 64'h40, 64'h0, 8'h00, 64'h0BADFFFF12345678, 0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning the byte address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning the number of storage words (power of 2).
REQ-004 SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to response (range 1..15).
REQ-005 SHALL have ports:
  clk  input  1  single clock; all logic rising-edge.
  rst_n  input  1  asynchronous, active-low reset.
  mem_addr  input  ADDR_WIDTH  byte address.
  mem_write_data  input  DATA_WIDTH  store data.
  mem_byte_en  input  DATA_WIDTH/8  per-byte write enable.
  mem_read  input  1  load request.
  mem_write  input  1  store request.
  mem_req_ready  output  1  request accepted this cycle if asserted with mem_read or mem_write.
  mem_read_data  output  DATA_WIDTH  load data, valid with mem_resp_valid.
  mem_resp_valid  output  1  one-cycle response pulse.
  mem_err  output  1  access error, valid with mem_resp_valid.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-007 SHALL drive mem_req_ready=1 only in IDLE.
REQ-008 SHALL accept a request at the edge where the FSM is in IDLE and (mem_read|mem_write)=1.
- LATENCY=1: next state RESP.
- Otherwise: next state WAIT with the counter loaded to LATENCY-1.
REQ-009 SHALL decrement the counter in WAIT and go to RESP when it reaches 1.
REQ-010 SHALL hold mem_resp_valid=1 for exactly one cycle in RESP, then return to IDLE.
- An accept at edge N gives the response in cycle N+LATENCY.
- Request spacing is at least LATENCY+1 cycles.
REQ-011 SHALL have no response backpressure; the requester must sample on mem_resp_valid.
REQ-012 SHALL form the word index as mem_addr[$clog2(DEPTH)+2:3].
REQ-013 SHALL commit a store at the accept edge, writing only the bytes whose mem_byte_en bit is 1.
REQ-014 SHALL capture load data at the accept edge and hold it until RESP; a store's response returns mem_read_data=0.
REQ-015 SHALL treat mem_read and mem_write both asserted as a store (store priority); the response carries data 0.
REQ-016 SHALL drive mem_read_data=0 and mem_err=0 whenever mem_resp_valid=0.
REQ-017 SHALL ignore request inputs while not in IDLE.

Reset
REQ-018 SHALL on rst_n=0 immediately force: state IDLE, counter 0, mem_resp_valid 0, mem_read_data 0, mem_err 0.
- mem_req_ready becomes 1 once in IDLE.
REQ-019 SHALL drop any pending response when reset asserts mid-operation; a store already committed remains in the array.
REQ-020 SHALL NOT reset the storage array contents.

Configuration
REQ-021 SHALL, with macro DMEM_RESPONDER_ERR_EN defined, flag an error when mem_addr[2:0]!=0 or any mem_addr bit above $clog2(DEPTH)+2 is set.
- The store is suppressed and the load data is 0.
- mem_err=1 with mem_resp_valid.
- Latency is unchanged.
REQ-022 SHALL, without DMEM_RESPONDER_ERR_EN, ignore the low and upper address bits (the address aliases) and tie mem_err to 0.

Structure
REQ-023 SHALL place the FSM state enum and the default DEPTH/LATENCY constants in shared package dmem_pkg.
REQ-024 SHALL contain one sub-module, dmem_array: a single-port synchronous RAM with byte enables.

Verification
REQ-025 Store, default params: addr 0x10, data 0x1122334455667788, byte_en 0xFF, then a load of 0x10 -> resp_valid two cycles after each accept; load data 0x1122334455667788.
REQ-026 Partial store to 0x10: byte_en 0x0F, data 0xAAAAAAAAAAAAAAAA, then a load -> 0x11223344AAAAAAAA.
REQ-027 Hold mem_read high continuously -> mem_req_ready low for two cycles after each accept; accepts every three cycles; one resp_valid per accept.
REQ-028 Assert rst_n=0 in the cycle after accepting a load -> no resp_valid; ready=1 after release; the next load of 0x10 returns the stored data.
REQ-029 With DMEM_RESPONDER_ERR_EN, load at 0x13 and store to 0x800 -> mem_err=1 and data 0 on both; a later load of 0x10 is unchanged. Without the macro: the 0x13 load returns the word at 0x10; mem_err stays 0.
REQ-030 LATENCY=1 with mem_read and mem_write both asserted -> the store commits, resp_valid arrives the next cycle with data 0, and a following load returns the stored value.
